// File: rtl/sorting_engine_v2.sv
// In-place exchange sorter over a 2**L x N register array with host load/readback,
// runtime element count, ascending/descending order and signed/unsigned compare.
module sorting_engine_v2 #(
  parameter int unsigned N = 8,
  parameter int unsigned L = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           Rd,
  input  logic           WrInit,
  input  logic [L-1:0]   RAddr,
  input  logic [N-1:0]   DataIn,
  input  logic           start,
  input  logic [L:0]     Cnt,
  input  logic           Desc,
  input  logic           SignedMode,
  output logic [N-1:0]   DataOut,
  output logic           done,
  output logic           busy,
  output logic [2*L-1:0] SwapCnt
);

  localparam int unsigned DEPTH = 2**L;
  localparam int unsigned IW    = L + 1;
  localparam int unsigned SW    = 2 * L;

  typedef enum logic [2:0] {
    S_IDLE, S_RDA, S_RDB, S_CMP, S_SWJ, S_SWI, S_DONE
  } state_t;

  state_t          state, state_nxt;
  logic [N-1:0]    mem [DEPTH];
  logic [IW-1:0]   i, j, kc;
  logic [N-1:0]    a, b;
  logic            desc_q, sgn_q;

  logic [IW-1:0]   cnt_c;
  logic            swap_c, adv_j_c, adv_i_c, adv_en_c, rd_c;
  logic            mem_we_c;
  logic [L-1:0]    mem_wa_c;
  logic [N-1:0]    mem_wd_c;

  // Element count clamped to the memory depth
  assign cnt_c = (Cnt > IW'(DEPTH)) ? IW'(DEPTH) : Cnt;

  assign adv_j_c = (j < kc - IW'(1));
  assign adv_i_c = (i < kc - IW'(2));

  always_comb begin
    logic gt, lt;
    gt     = sgn_q ? ($signed(a) > $signed(b)) : (a > b);
    lt     = sgn_q ? ($signed(a) < $signed(b)) : (a < b);
    swap_c = desc_q ? lt : gt;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_t adv_s;
    state_nxt = state;
    adv_s     = adv_j_c ? S_RDB : (adv_i_c ? S_RDA : S_DONE);
    case (state)
      S_IDLE: if (start) state_nxt = (cnt_c < IW'(2)) ? S_DONE : S_RDA;
      S_RDA:  state_nxt = S_RDB;
      S_RDB:  state_nxt = S_CMP;
      S_CMP:  state_nxt = swap_c ? S_SWJ : adv_s;
      S_SWJ:  state_nxt = S_SWI;
      S_SWI:  state_nxt = adv_s;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath strobes: host port is live only in IDLE and DONE
  always_comb begin
    mem_we_c = 1'b0;
    mem_wa_c = RAddr;
    mem_wd_c = DataIn;
    rd_c     = 1'b0;
    adv_en_c = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        mem_we_c = WrInit;
        rd_c     = Rd;
      end
      S_CMP: adv_en_c = !swap_c;
      S_SWJ: begin
        mem_we_c = 1'b1;
        mem_wa_c = j[L-1:0];
        mem_wd_c = a;
      end
      S_SWI: begin
        mem_we_c = 1'b1;
        mem_wa_c = i[L-1:0];
        mem_wd_c = b;
        adv_en_c = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we_c) mem[mem_wa_c] <= mem_wd_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i       <= '0;
      j       <= '0;
      a       <= '0;
      b       <= '0;
      kc      <= '0;
      desc_q  <= 1'b0;
      sgn_q   <= 1'b0;
      DataOut <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
      SwapCnt <= '0;
    end else begin
      done <= (state_nxt == S_DONE);
      busy <= (state_nxt inside {S_RDA, S_RDB, S_CMP, S_SWJ, S_SWI});
      if (rd_c) DataOut <= mem[RAddr];
      case (state)
        S_IDLE: if (start) begin
          kc      <= cnt_c;
          desc_q  <= Desc;
          sgn_q   <= SignedMode;
          SwapCnt <= '0;
          i       <= '0;
        end
        S_RDA: begin
          a <= mem[i[L-1:0]];
          j <= i + IW'(1);
        end
        S_RDB: b <= mem[j[L-1:0]];
        S_SWI: begin
          a       <= b;
          SwapCnt <= SwapCnt + SW'(1);
        end
        default: ;
      endcase
      if (adv_en_c) begin
        if (adv_j_c)      j <= j + IW'(1);
        else if (adv_i_c) i <= i + IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_sorting_engine_v2.sv
// Self-checking bench for sorting_engine_v2: random and directed sorts compared
// against an array-based exchange-sort model.
module tb_sorting_engine_v2;

  logic       clk = 1'b0;
  logic       rst, Rd, WrInit, start, Desc, SignedMode;
  logic [3:0] RAddr;
  logic [7:0] DataIn;
  logic [4:0] Cnt;
  logic [7:0] DataOut;
  logic       done, busy;
  logic [7:0] SwapCnt;

  int compared   = 0;
  int mismatched = 0;

  logic [7:0] mm [16];
  logic [7:0] rb [16];

  sorting_engine_v2 #(.N(8), .L(4)) dut (
    .clk(clk), .rst(rst), .Rd(Rd), .WrInit(WrInit), .RAddr(RAddr),
    .DataIn(DataIn), .start(start), .Cnt(Cnt), .Desc(Desc),
    .SignedMode(SignedMode), .DataOut(DataOut), .done(done), .busy(busy),
    .SwapCnt(SwapCnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit out_of_order(input logic [7:0] x, input logic [7:0] y,
                                      input bit desc, input bit sgn);
    int vx, vy;
    vx = sgn ? int'($signed(x)) : int'({24'd0, x});
    vy = sgn ? int'($signed(y)) : int'({24'd0, y});
    return desc ? (vx < vy) : (vx > vy);
  endfunction

  // Exchange sort on the model array: pair (i,j>i) swaps when out of order
  task automatic model_sort(input int k, input bit desc, input bit sgn, output int swaps);
    logic [7:0] t;
    swaps = 0;
    for (int p = 0; p < k - 1; p++)
      for (int q = p + 1; q < k; q++)
        if (out_of_order(mm[p], mm[q], desc, sgn)) begin
          t = mm[p]; mm[p] = mm[q]; mm[q] = t;
          swaps++;
        end
  endtask

  task automatic write_word(input int addr, input logic [7:0] d);
    WrInit = 1'b1; RAddr = 4'(addr); DataIn = d;
    tick();
    WrInit = 1'b0;
    mm[addr] = d;
  endtask

  task automatic readback_all();
    for (int a = 0; a < 16; a++) begin
      Rd = 1'b1; RAddr = 4'(a);
      tick();
      Rd = 1'b0;
      rb[a] = DataOut;
      check($sformatf("readback[%0d]", a), DataOut, mm[a]);
    end
  endtask

  task automatic run_sort(input int cnt, input bit desc, input bit sgn, input bit interfere,
                          output int nb, output int swaps);
    int k, exp_cycles;
    bit got;
    logic [7:0] d0;
    k  = (cnt > 16) ? 16 : cnt;
    d0 = DataOut;
    model_sort(k, desc, sgn, swaps);
    Cnt = 5'(cnt); Desc = desc; SignedMode = sgn; start = 1'b1;
    tick();
    start = 1'b0;
    nb = 0; got = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (done) begin got = 1'b1; break; end
      check("busy_during_sort", busy, 1);
      check("dataout_hold", DataOut, d0);
      nb++;
      if (interfere && c == 3) begin
        WrInit = 1'b1; Rd = 1'b1; start = 1'b1; RAddr = 4'd0; DataIn = 8'h55;
      end
      tick();
      WrInit = 1'b0; Rd = 1'b0; start = 1'b0;
    end
    check("done_seen", got, 1);
    check("busy_at_done", busy, 0);
    exp_cycles = (k < 2) ? 0 : (k - 1) + k * (k - 1) + 2 * swaps;
    check("busy_cycles", nb, exp_cycles);
    check("swapcnt", SwapCnt, swaps);
    tick();
    check("done_width", done, 0);
    check("busy_after", busy, 0);
    readback_all();
    for (int t = 0; t + 1 < k; t++)
      check("dut_sorted", out_of_order(rb[t], rb[t+1], desc, sgn), 0);
  endtask

  initial begin
    int nb, sw;
    logic [7:0] e3a [4];
    logic [7:0] e3b [4];
    e3a = '{8'h80, 8'hFF, 8'h01, 8'h7F};
    e3b = '{8'hFF, 8'h80, 8'h7F, 8'h01};
    rst = 1'b1; Rd = 1'b0; WrInit = 1'b0; start = 1'b0; Desc = 1'b0;
    SignedMode = 1'b0; RAddr = '0; DataIn = '0; Cnt = '0;
    for (int a = 0; a < 16; a++) mm[a] = 8'h00;
    tick(); tick();
    check("reset_dataout", DataOut, 0);
    check("reset_done", done, 0);
    check("reset_busy", busy, 0);
    check("reset_swapcnt", SwapCnt, 0);
    rst = 1'b0;
    for (int a = 0; a < 16; a++) write_word(a, 8'h00);

    // 1: already sorted
    for (int a = 0; a < 8; a++) write_word(a, 8'(a + 1));
    run_sort(8, 1'b0, 1'b0, 1'b0, nb, sw);
    check("t1_busy63", nb, 63);
    check("t1_swaps0", SwapCnt, 0);
    for (int a = 0; a < 8; a++) check("t1_unchanged", rb[a], a + 1);

    // 2: reverse order, full depth
    for (int a = 0; a < 16; a++) write_word(a, 8'(15 - a));
    run_sort(16, 1'b0, 1'b0, 1'b0, nb, sw);
    check("t2_swaps120", SwapCnt, 120);
    check("t2_busy495", nb, 495);
    for (int a = 0; a < 16; a++) check("t2_sorted", rb[a], a);

    // 3: signed ascending, then unsigned descending
    write_word(0, 8'h80); write_word(1, 8'h7F); write_word(2, 8'hFF); write_word(3, 8'h01);
    run_sort(4, 1'b0, 1'b1, 1'b0, nb, sw);
    for (int a = 0; a < 4; a++) check("t3_signed_asc", rb[a], e3a[a]);
    write_word(0, 8'h80); write_word(1, 8'h7F); write_word(2, 8'hFF); write_word(3, 8'h01);
    run_sort(4, 1'b1, 1'b0, 1'b0, nb, sw);
    for (int a = 0; a < 4; a++) check("t3_unsigned_desc", rb[a], e3b[a]);

    // 4: partial count leaves the tail untouched; trivial counts
    for (int a = 0; a < 16; a++) write_word(a, (a < 5) ? 8'($urandom_range(0, 255)) : 8'hAA);
    run_sort(5, 1'b0, 1'b0, 1'b0, nb, sw);
    for (int a = 5; a < 16; a++) check("t4_tail", rb[a], 8'hAA);
    write_word(0, 8'h33);
    run_sort(1, 1'b0, 1'b0, 1'b0, nb, sw);
    check("t4_cnt1_swap", SwapCnt, 0);
    run_sort(0, 1'b1, 1'b0, 1'b0, nb, sw);
    check("t4_cnt0_busy", nb, 0);

    // 5: host traffic during busy is ignored
    for (int a = 0; a < 16; a++) write_word(a, 8'(15 - a));
    run_sort(16, 1'b0, 1'b0, 1'b1, nb, sw);

    // 6: reset mid-sort
    for (int a = 0; a < 16; a++) write_word(a, 8'(15 - a));
    Cnt = 5'd16; Desc = 1'b0; SignedMode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 40; c++) tick();
    rst = 1'b1;
    tick();
    check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    check("t6_swapcnt", SwapCnt, 0);
    check("t6_dataout", DataOut, 0);
    rst = 1'b0;
    for (int a = 0; a < 16; a++) write_word(a, 8'($urandom_range(0, 255)));
    run_sort(16, 1'b1, 1'b1, 1'b0, nb, sw);

    // Randomized runs, including counts above the depth
    for (int r = 0; r < 8; r++) begin
      for (int a = 0; a < 16; a++) write_word(a, 8'($urandom_range(0, 255)));
      run_sort(int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), nb, sw);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
